// File: rtl/lisnoc_dma_request_scheduler_pkg.sv
// Shared definitions for the LISNoC DMA request scheduler.
// Request word width and scheduler FSM encodings.
package lisnoc_dma_request_scheduler_pkg;

   localparam int DMA_REQUEST_WIDTH = 103;

   typedef enum logic [1:0] {
      DMA_SCHED_IDLE  = 2'd0,
      DMA_SCHED_FETCH = 2'd1,
      DMA_SCHED_ISSUE = 2'd2
   } dma_sched_state_e;

endpackage

// File: rtl/lisnoc_dma_rr_pick.sv
// Combinational round-robin picker: the search starts one past
// i_last and wraps; o_any flags that some request bit is set.
module lisnoc_dma_rr_pick #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_last,
   output logic [PW-1:0] o_win,
   output logic          o_any
);

   function automatic logic [PW-1:0] f_idx(
      input logic [PW-1:0] last,
      input int            k
   );
      int s;
      s = (int'(last) + k) % N;
      return PW'(s);
   endfunction

   // Walk from the lowest priority to the highest, so the last hit wins.
   always_comb begin
      o_win = '0;
      o_any = 1'b0;
      for (int k = N; k >= 1; k--) begin
         if (i_req[f_idx(i_last, k)]) begin
            o_win = f_idx(i_last, k);
            o_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lisnoc_dma_request_scheduler.sv
// Picks pending DMA table entries round-robin and issues them.
// Optional LISNOC_DMA_SCHED_STATS_EN adds issue/completion counters.
module lisnoc_dma_request_scheduler
   import lisnoc_dma_request_scheduler_pkg::*;
#(
   parameter  int table_entries          = 4,
   localparam int table_entries_ptrwidth = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [table_entries-1:0]          valid,
   output logic [table_entries_ptrwidth-1:0] ctrl_read_pos,
   input  logic [DMA_REQUEST_WIDTH-1:0]      ctrl_read_req,
   output logic [table_entries_ptrwidth-1:0] ctrl_done_pos,
   output logic                              ctrl_done_en,
   output logic [DMA_REQUEST_WIDTH-1:0]      out_req,
   output logic [table_entries_ptrwidth-1:0] out_pos,
   output logic                              out_valid,
   input  logic                              out_ready,
   input  logic [table_entries_ptrwidth-1:0] cpl_pos,
   input  logic                              cpl_en,
   output logic [table_entries-1:0]          inflight,
   output logic                              busy
`ifdef LISNOC_DMA_SCHED_STATS_EN
   ,
   output logic [15:0]                       issue_count,
   output logic [15:0]                       cpl_count
`endif
);

   localparam int N  = table_entries;
   localparam int PW = table_entries_ptrwidth;

   dma_sched_state_e       r_state;
   logic [PW-1:0]          r_sel;
   logic [PW-1:0]          r_last;
   logic [PW-1:0]          r_out_pos;
   logic [DMA_REQUEST_WIDTH-1:0] r_out_req;
   logic                   r_out_valid;
   logic [N-1:0]           r_inflight;

   logic [N-1:0]           w_cand;
   logic [N-1:0]           w_inflight_nxt;
   logic [PW-1:0]          w_win;
   logic                   w_any;
   logic                   w_sel_active;

   assign w_cand       = valid & ~r_inflight;
   assign w_sel_active = (r_state != DMA_SCHED_IDLE);

   lisnoc_dma_rr_pick #(
      .N  (N),
      .PW (PW)
   ) u_pick (
      .i_req  (w_cand),
      .i_last (r_last),
      .o_win  (w_win),
      .o_any  (w_any)
   );

   // Set beats completion/software clear for the entry being fetched.
   always_comb begin
      w_inflight_nxt = r_inflight;
      for (int i = 0; i < N; i++) begin
         if (!valid[i] && !(w_sel_active && r_sel == PW'(i)))
            w_inflight_nxt[i] = 1'b0;
      end
      if (cpl_en)
         w_inflight_nxt[cpl_pos] = 1'b0;
      if (r_state == DMA_SCHED_FETCH && valid[r_sel])
         w_inflight_nxt[r_sel] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= DMA_SCHED_IDLE;
         r_sel       <= '0;
         r_last      <= PW'(N - 1);
         r_out_pos   <= '0;
         r_out_req   <= '0;
         r_out_valid <= 1'b0;
         r_inflight  <= '0;
      end else begin
         r_inflight <= w_inflight_nxt;
         case (r_state)
            DMA_SCHED_IDLE: begin
               if (w_any) begin
                  r_sel   <= w_win;
                  r_state <= DMA_SCHED_FETCH;
               end
            end
            DMA_SCHED_FETCH: begin
               if (!valid[r_sel]) begin
                  r_state <= DMA_SCHED_IDLE;
               end else begin
                  r_out_req   <= ctrl_read_req;
                  r_out_pos   <= r_sel;
                  r_out_valid <= 1'b1;
                  r_state     <= DMA_SCHED_ISSUE;
               end
            end
            DMA_SCHED_ISSUE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_last      <= r_sel;
                  r_state     <= DMA_SCHED_IDLE;
               end
            end
            default: r_state <= DMA_SCHED_IDLE;
         endcase
      end
   end

   assign ctrl_read_pos = r_sel;
   assign ctrl_done_en  = cpl_en;
   assign ctrl_done_pos = cpl_pos;
   assign out_req       = r_out_req;
   assign out_pos       = r_out_pos;
   assign out_valid     = r_out_valid;
   assign inflight      = r_inflight;
   assign busy          = w_sel_active | (|r_inflight);

`ifdef LISNOC_DMA_SCHED_STATS_EN
   logic [15:0] r_issue_count;
   logic [15:0] r_cpl_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_issue_count <= '0;
         r_cpl_count   <= '0;
      end else begin
         if (r_out_valid && out_ready)
            r_issue_count <= r_issue_count + 16'd1;
         if (cpl_en)
            r_cpl_count <= r_cpl_count + 16'd1;
      end
   end

   assign issue_count = r_issue_count;
   assign cpl_count   = r_cpl_count;
`endif

endmodule

// File: tb/tb_lisnoc_dma_request_scheduler.sv
// Bench for lisnoc_dma_request_scheduler: directed scenarios plus a
// randomized run against a transaction-level table/scheduler model.
module tb_lisnoc_dma_request_scheduler;
   import lisnoc_dma_request_scheduler_pkg::*;

   localparam int N = 4;
   localparam int W = DMA_REQUEST_WIDTH;

   logic          clk;
   logic          rst;
   logic [N-1:0]  valid;
   logic [1:0]    ctrl_read_pos;
   logic [W-1:0]  ctrl_read_req;
   logic [1:0]    ctrl_done_pos;
   logic          ctrl_done_en;
   logic [W-1:0]  out_req;
   logic [1:0]    out_pos;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    cpl_pos;
   logic          cpl_en;
   logic [N-1:0]  inflight;
   logic          busy;
`ifdef LISNOC_DMA_SCHED_STATS_EN
   logic [15:0]   issue_count;
   logic [15:0]   cpl_count;
`endif

   logic [W-1:0]  table_mem [N];
   int            n_checks;
   int            n_fail;

   assign ctrl_read_req = table_mem[ctrl_read_pos];

   lisnoc_dma_request_scheduler #(
      .table_entries (N)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .valid         (valid),
      .ctrl_read_pos (ctrl_read_pos),
      .ctrl_read_req (ctrl_read_req),
      .ctrl_done_pos (ctrl_done_pos),
      .ctrl_done_en  (ctrl_done_en),
      .out_req       (out_req),
      .out_pos       (out_pos),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .cpl_pos       (cpl_pos),
      .cpl_en        (cpl_en),
      .inflight      (inflight),
      .busy          (busy)
`ifdef LISNOC_DMA_SCHED_STATS_EN
      ,
      .issue_count   (issue_count),
      .cpl_count     (cpl_count)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [W-1:0] rnd_word();
      logic [127:0] t;
      t = {$urandom, $urandom, $urandom, $urandom};
      return t[W-1:0];
   endfunction

   // Round-robin rule: first candidate at last+1, last+2, ... mod N.
   function automatic int rr_next(input int last, input logic [N-1:0] cand);
      int idx;
      for (int k = 1; k <= N; k++) begin
         idx = (last + k) % N;
         if (cand[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      valid = '0;
      out_ready = 1'b0;
      cpl_en = 1'b0;
      cpl_pos = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      valid = '0;
      out_ready = 1'b0;
      cpl_en = 1'b0;
      cpl_pos = '0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      n_checks++;
      if (out_req !== '0) begin
         n_fail++; $display("FAIL reset_out_req: got %h expected 0", out_req);
      end
      n_checks++;
      if (out_pos !== 2'd0) begin
         n_fail++; $display("FAIL reset_out_pos: got %0d expected 0", out_pos);
      end
      n_checks++;
      if (ctrl_read_pos !== 2'd0) begin
         n_fail++; $display("FAIL reset_read_pos: got %0d expected 0", ctrl_read_pos);
      end
      n_checks++;
      if (inflight !== 4'b0000) begin
         n_fail++; $display("FAIL reset_inflight: got %b expected 0000", inflight);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy: got %b expected 0", busy);
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      int extra;
      valid = 4'b0100;
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ctrl_read_pos !== 2'd2 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_fetch: got pos %0d valid %b expected pos 2 valid 0",
                  ctrl_read_pos, out_valid);
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_pos !== 2'd2) begin
         n_fail++;
         $display("FAIL single_issue: got valid %b pos %0d expected 1 pos 2",
                  out_valid, out_pos);
      end
      n_checks++;
      if (out_req !== table_mem[2]) begin
         n_fail++; $display("FAIL single_req: got %h expected %h", out_req, table_mem[2]);
      end
      n_checks++;
      if (inflight !== 4'b0100) begin
         n_fail++; $display("FAIL single_inflight: got %b expected 0100", inflight);
      end
      @(negedge clk);
      extra = 0;
      repeat (4) begin
         if (out_valid) extra++;
         @(negedge clk);
      end
      n_checks++;
      if (extra != 0) begin
         n_fail++; $display("FAIL single_reissue: got %0d issues expected 0", extra);
      end
      cpl_en = 1'b1;
      cpl_pos = 2'd2;
      valid = 4'b0000;
      @(negedge clk);
      cpl_en = 1'b0;
      n_checks++;
      if (inflight !== 4'b0000) begin
         n_fail++; $display("FAIL single_cpl_clear: got %b expected 0000", inflight);
      end
   endtask

   task automatic test_fairness();
      int seq[$];
      do_reset();
      valid = 4'b1111;
      out_ready = 1'b1;
      repeat (24) begin
         @(negedge clk);
         if (out_valid) begin
            seq.push_back(int'(out_pos));
            n_checks++;
            if (out_req !== table_mem[out_pos]) begin
               n_fail++;
               $display("FAIL fair_req: got %h expected %h", out_req, table_mem[out_pos]);
            end
         end
      end
      n_checks++;
      if (seq.size() != 4) begin
         n_fail++; $display("FAIL fair_count: got %0d issues expected 4", seq.size());
      end
      for (int i = 0; i < seq.size() && i < 4; i++) begin
         n_checks++;
         if (seq[i] != i) begin
            n_fail++; $display("FAIL fair_order: issue %0d got %0d expected %0d", i, seq[i], i);
         end
      end
      n_checks++;
      if (inflight !== 4'b1111) begin
         n_fail++; $display("FAIL fair_inflight: got %b expected 1111", inflight);
      end
      valid = 4'b0000;
      repeat (2) @(negedge clk);
      n_checks++;
      if (inflight !== 4'b0000) begin
         n_fail++; $display("FAIL fair_sw_clear: got %b expected 0000", inflight);
      end
   endtask

   task automatic test_back_pressure();
      int t;
      logic [W-1:0] s_req;
      valid = 4'b0001;
      out_ready = 1'b0;
      t = 0;
      do begin @(negedge clk); t++; end while (!out_valid && t < 6);
      n_checks++;
      if (out_valid !== 1'b1 || out_pos !== 2'd0) begin
         n_fail++;
         $display("FAIL bp_issue: got valid %b pos %0d expected 1 pos 0", out_valid, out_pos);
      end
      s_req = table_mem[0];
      valid = 4'b0000;
      repeat (5) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b1 || out_req !== s_req || out_pos !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_stable: got valid %b pos %0d req %h expected 1 0 %h",
                     out_valid, out_pos, out_req, s_req);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL bp_handshake: got valid %b expected 0", out_valid);
      end
      @(negedge clk);
      n_checks++;
      if (inflight !== 4'b0000) begin
         n_fail++; $display("FAIL bp_inflight: got %b expected 0000", inflight);
      end
   endtask

   task automatic test_completion();
      int t;
      int extra;
      valid = 4'b0010;
      out_ready = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!out_valid && t < 6);
      n_checks++;
      if (out_valid !== 1'b1 || out_pos !== 2'd1) begin
         n_fail++;
         $display("FAIL cpl_issue: got valid %b pos %0d expected 1 pos 1", out_valid, out_pos);
      end
      @(negedge clk);
      n_checks++;
      if (inflight !== 4'b0010 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL cpl_pre: got inflight %b valid %b expected 0010 0", inflight, out_valid);
      end
      cpl_en = 1'b1;
      cpl_pos = 2'd1;
      #1;
      n_checks++;
      if (ctrl_done_en !== 1'b1 || ctrl_done_pos !== 2'd1) begin
         n_fail++;
         $display("FAIL cpl_forward: got en %b pos %0d expected 1 pos 1",
                  ctrl_done_en, ctrl_done_pos);
      end
      @(negedge clk);
      valid = 4'b0000;
      cpl_en = 1'b0;
      n_checks++;
      if (inflight !== 4'b0000) begin
         n_fail++; $display("FAIL cpl_clear: got %b expected 0000", inflight);
      end
      #1;
      n_checks++;
      if (ctrl_done_en !== 1'b0) begin
         n_fail++; $display("FAIL cpl_idle: got en %b expected 0", ctrl_done_en);
      end
      extra = 0;
      repeat (4) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      n_checks++;
      if (extra != 0) begin
         n_fail++; $display("FAIL cpl_reissue: got %0d issues expected 0", extra);
      end
      cpl_en = 1'b1;
      cpl_pos = 2'd3;
      #1;
      n_checks++;
      if (ctrl_done_en !== 1'b1 || ctrl_done_pos !== 2'd3) begin
         n_fail++;
         $display("FAIL cpl_stray_fwd: got en %b pos %0d expected 1 pos 3",
                  ctrl_done_en, ctrl_done_pos);
      end
      @(negedge clk);
      cpl_en = 1'b0;
      n_checks++;
      if (inflight !== 4'b0000 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL cpl_stray: got inflight %b valid %b expected 0000 0", inflight, out_valid);
      end
   endtask

   task automatic test_withdrawal();
      int extra;
      valid = 4'b1000;
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ctrl_read_pos !== 2'd3 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL wd_fetch: got pos %0d valid %b expected pos 3 valid 0",
                  ctrl_read_pos, out_valid);
      end
      valid = 4'b0000;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || inflight !== 4'b0000 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL wd_idle: got valid %b inflight %b busy %b expected 0 0000 0",
                  out_valid, inflight, busy);
      end
      extra = 0;
      repeat (3) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      n_checks++;
      if (extra != 0) begin
         n_fail++; $display("FAIL wd_issue: got %0d issues expected 0", extra);
      end
   endtask

   task automatic test_reset_mid_issue();
      int t;
      valid = 4'b0100;
      out_ready = 1'b0;
      t = 0;
      do begin @(negedge clk); t++; end while (!out_valid && t < 6);
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++; $display("FAIL rmi_issue: got valid %b expected 1", out_valid);
      end
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || inflight !== 4'b0000 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rmi_reset: got valid %b inflight %b busy %b expected 0 0000 0",
                  out_valid, inflight, busy);
      end
`ifdef LISNOC_DMA_SCHED_STATS_EN
      n_checks++;
      if (issue_count !== 16'd0 || cpl_count !== 16'd0) begin
         n_fail++;
         $display("FAIL rmi_stats: got %0d %0d expected 0 0", issue_count, cpl_count);
      end
`endif
      rst = 1'b0;
      valid = 4'b1111;
      out_ready = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!out_valid && t < 6);
      n_checks++;
      if (out_valid !== 1'b1 || out_pos !== 2'd0) begin
         n_fail++;
         $display("FAIL rmi_first: got valid %b pos %0d expected 1 pos 0", out_valid, out_pos);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] pending;
      logic [N-1:0] minf;
      logic [N-1:0] cand;
      logic [W-1:0] cur_req;
      int last, exp_pos, cur_pos, wait_cnt, issued;
      bit issuing, waiting, hs;
      int elig[$];
      int j;
      do_reset();
      pending = '0;
      minf = '0;
      last = N - 1;
      issuing = 0;
      waiting = 0;
      hs = 0;
      issued = 0;
      exp_pos = 0;
      cur_pos = 0;
      cur_req = '0;
      wait_cnt = 0;
      repeat (600) begin
         @(negedge clk);
         cpl_en = 1'b0;
         if (hs) begin
            last = cur_pos;
            issuing = 0;
            hs = 0;
            n_checks++;
            if (out_valid !== 1'b0) begin
               n_fail++; $display("FAIL rnd_drop: got valid %b expected 0", out_valid);
            end
         end
         if (out_valid === 1'b1 && !issuing) begin
            n_checks++;
            if (!waiting) begin
               n_fail++; $display("FAIL rnd_spurious: got issue pos %0d expected none", out_pos);
            end else if (int'(out_pos) != exp_pos || out_req !== table_mem[exp_pos]) begin
               n_fail++;
               $display("FAIL rnd_pick: got pos %0d req %h expected pos %0d req %h",
                        out_pos, out_req, exp_pos, table_mem[exp_pos]);
            end
            issuing = 1;
            waiting = 0;
            cur_pos = int'(out_pos);
            cur_req = out_req;
            minf[cur_pos] = 1'b1;
            issued++;
         end else if (issuing) begin
            n_checks++;
            if (out_valid !== 1'b1 || int'(out_pos) != cur_pos || out_req !== cur_req) begin
               n_fail++;
               $display("FAIL rnd_hold: got valid %b pos %0d expected 1 pos %0d",
                        out_valid, out_pos, cur_pos);
            end
         end
         if (waiting) begin
            wait_cnt++;
            if (wait_cnt > 3) begin
               n_checks++;
               n_fail++;
               $display("FAIL rnd_timeout: got no issue expected pos %0d", exp_pos);
               waiting = 0;
            end
         end
         n_checks++;
         if (inflight !== minf) begin
            n_fail++; $display("FAIL rnd_inflight: got %b expected %b", inflight, minf);
         end
         if (issuing || !waiting) begin
            for (int i = 0; i < N; i++) begin
               if (!pending[i] && ($urandom % 4) == 0) begin
                  table_mem[i] = rnd_word();
                  pending[i] = 1'b1;
               end
            end
            elig.delete();
            for (int i = 0; i < N; i++)
               if (minf[i] && !(issuing && i == cur_pos)) elig.push_back(i);
            if (elig.size() > 0 && ($urandom % 3) == 0) begin
               j = elig[$urandom_range(elig.size() - 1)];
               cpl_en = 1'b1;
               cpl_pos = 2'(j);
               pending[j] = 1'b0;
               minf[j] = 1'b0;
            end
            valid = pending;
         end
         if (issuing) begin
            out_ready = (($urandom % 3) == 0);
            hs = out_ready;
         end else begin
            out_ready = 1'b0;
         end
         if (!issuing && !waiting) begin
            cand = pending & ~minf;
            if (cand != '0) begin
               waiting = 1;
               wait_cnt = 0;
               exp_pos = rr_next(last, cand);
            end
         end
      end
      n_checks++;
      if (issued < 20) begin
         n_fail++; $display("FAIL rnd_volume: got %0d issues expected at least 20", issued);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      for (int i = 0; i < N; i++) table_mem[i] = rnd_word();
      test_reset();
      test_single();
      test_fairness();
      test_back_pressure();
      test_completion();
      test_withdrawal();
      test_reset_mid_issue();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lisnoc_dma_request_scheduler.md
Name: lisnoc_dma_request_scheduler

Overview:
Control-side consumer of the DMA request table. It watches the per-entry valid vector and picks the next pending, not-yet-issued entry round-robin. It reads that entry's request word through the table's control read port and hands it to the packet initiator with a valid/ready handshake. Completions from the initiator are forwarded to the table's done-write port with zero latency.

Parameters:
table_entries, 4, number of request-table entries; must match the table.
table_entries_ptrwidth (localparam), 2, entry index width; fixed to match the table.

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
valid  input  table_entries  table valid vector (valid & ~done per entry)
ctrl_read_pos  output  ptrwidth  entry index driven to the table read port; registered
ctrl_read_req  input  DMA_REQUEST_WIDTH  request word from the table; combinational w.r.t. ctrl_read_pos
ctrl_done_pos  output  ptrwidth  completed entry index to the table
ctrl_done_en  output  1  completion strobe to the table
out_req  output  DMA_REQUEST_WIDTH  request word issued to the initiator
out_pos  output  ptrwidth  table index of out_req
out_valid  output  1  issue handshake valid
out_ready  input  1  issue handshake ready
cpl_pos  input  ptrwidth  index of the entry the initiator finished
cpl_en  input  1  completion strobe from the initiator
inflight  output  table_entries  entries issued but not yet completed
busy  output  1  FSM not in IDLE, or inflight non-zero

Behaviour:
- Reset values: out_valid=0, out_req=0, out_pos=0, ctrl_read_pos=0, inflight=0, last_grant=table_entries-1, FSM=IDLE. Reset mid-handshake drops out_valid immediately; no completion is generated.
- cand = valid & ~inflight.
- Round-robin search starts at last_grant+1, modulo table_entries, and wraps.
- FSM state IDLE:
  - If cand≠0, register the round-robin winner into sel and ctrl_read_pos, then go to FETCH.
  - Otherwise stay in IDLE.
- FSM state FETCH (one cycle):
  - If valid[sel]=0, the entry was withdrawn by the interface; return to IDLE, issuing nothing.
  - Otherwise latch ctrl_read_req into out_req and sel into out_pos, set out_valid=1, set inflight[sel]=1, and go to ISSUE.
- FSM state ISSUE:
  - out_valid, out_req and out_pos are held stable until out_ready=1.
  - On the handshake cycle: out_valid=0, last_grant=sel, go to IDLE.
  - Once asserted, out_valid is never withdrawn except by rst, even if valid[sel] falls.
- Minimum issue spacing is 3 cycles per request (IDLE→FETCH→ISSUE with out_ready=1).
- Completion path (combinational):
  - ctrl_done_en=cpl_en and ctrl_done_pos=cpl_pos.
  - At the same clock edge, inflight[cpl_pos] is cleared. The table therefore sets done and the scheduler clears inflight on the same edge, so the entry is never re-selected.
  - A completion for an entry whose inflight bit is 0 is still forwarded and is otherwise ignored.
- Software clear: if valid[i]=0 and i is not sel in FETCH/ISSUE, inflight[i] is cleared.
- Simultaneous events:
  - A completion for entry j and a FETCH of entry k≠j both take effect.
  - A completion for the entry currently in FETCH/ISSUE is a protocol violation; set has priority.
- Index arithmetic is unsigned modulo 2^ptrwidth.

Optional Feature:
Macro: LISNOC_DMA_SCHED_STATS_EN
- When defined, adds output issue_count [15:0] and output cpl_count [15:0].
  - issue_count increments on each out_valid&out_ready.
  - cpl_count increments on each cpl_en.
  - Both counters wrap at 0xFFFF→0 and reset to 0.
- When undefined, neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- DMA_REQUEST_WIDTH and the request-field defines come from the shared lisnoc_dma_def.vh. Add the FSM state encodings there as DMA_SCHED_IDLE/FETCH/ISSUE.
- One sub-module: lisnoc_dma_rr_pick. It is combinational: inputs are the request vector and last_grant; outputs are the winner index and an any flag. It is reusable by other LISNoC arbiters.

Test Plan:
- Single request: valid=4'b0100, out_ready=1 → FETCH with ctrl_read_pos=2; out_valid high 2 cycles after valid; out_req=table[2]; inflight=4'b0100.
- Fairness: valid=4'b1111 held, out_ready=1, no cpl → issue order 0,1,2,3 and then no further issue; inflight=4'b1111.
- Backpressure: out_ready=0 for 5 cycles during ISSUE while the valid bit drops → out_valid/out_req/out_pos stable; handshake completes when ready rises.
- Completion: cpl_en=1, cpl_pos=1 with inflight[1]=1 → ctrl_done_en=1 and ctrl_done_pos=1 in the same cycle; inflight[1]=0 next cycle; entry 1 not re-issued while valid[1]=0.
- Withdrawal: valid[3] deasserted during FETCH of entry 3 → no out_valid; FSM back to IDLE; inflight[3]=0.
- Reset mid-ISSUE: rst during out_valid=1 → out_valid=0 and inflight=0 after the edge; next grant starts at entry 0. With LISNOC_DMA_SCHED_STATS_EN, counters read 0.
